// File: rtl/data_lsu.sv
// data_lsu: single-outstanding load/store unit in front of dataMem.
// Checks alignment/range, drives byte strobes, extends load data.
module data_lsu #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_DEPTH      = 256,
   parameter int TRANSFER_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [2:0]                req_funct3,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_err,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [TRANSFER_WIDTH-1:0] mem_wstrb,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACCESS  = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   logic [1:0]                state;
   logic [2:0]                f3_q;
   logic                      we_q;
   logic                      err;
   logic [31:0]               word_idx;
   logic [TRANSFER_WIDTH-1:0] strb;
   logic [DATA_WIDTH-1:0]     wrep;
   logic [DATA_WIDTH-1:0]     lane;
   logic [DATA_WIDTH-1:0]     ext;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign word_idx  = 32'(req_addr[ADDR_WIDTH-1:2]);

   always_comb begin
      err = 1'b0;
      case (req_funct3)
         3'b000:  err = 1'b0;
         3'b001:  err = req_addr[0];
         3'b010:  err = |req_addr[1:0];
         3'b100:  err = req_we;
         3'b101:  err = req_we | req_addr[0];
         default: err = 1'b1;
      endcase
      if (word_idx >= 32'(MEM_DEPTH)) err = 1'b1;
   end

   always_comb begin
      strb = '1;
      wrep = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            strb = TRANSFER_WIDTH'(1) << req_addr[1:0];
            wrep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            strb = TRANSFER_WIDTH'(3) << req_addr[1:0];
            wrep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // mem_addr still holds the request address during CAPTURE
   assign lane = mem_rdata >> {mem_addr[1:0], 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
         3'b100:  ext = {24'd0, lane[7:0]};
         3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
         3'b101:  ext = {16'd0, lane[15:0]};
         default: ext = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         f3_q      <= '0;
         we_q      <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               f3_q      <= req_funct3;
               we_q      <= req_we;
               rsp_rdata <= '0;
               rsp_err   <= err;
               if (err) begin
                  state <= RESP;
               end else begin
                  state     <= ACCESS;
                  mem_addr  <= req_addr;
                  mem_we    <= req_we;
                  mem_wdata <= wrep;
                  mem_wstrb <= req_we ? strb : '0;
               end
            end
            ACCESS: begin
               mem_we    <= 1'b0;
               mem_wstrb <= '0;
               state     <= we_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
               rsp_rdata <= ext;
               state     <= RESP;
            end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
